mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between the processor's instruction-fetch port (IF)
//  and its load/store port (D). Sits between the core and the RAM inside project3_frame.
//  Grants one access per cycle, tags each read return to its owner and prevents fetch
//  starvation. Data wins by default, with a bounded-wait override for fetch.
// PARAMETERS
//  ADDR_W     16  word-address width (RAM depth 2**ADDR_W words)
//  DATA_W     32  data word width
//  STARVE_MAX 3   consecutive denied IF cycles before IF is forced to win (1..15)
// PORTS
//  CLOCK_50   in   1       system clock, rising edge
//  RESET_N    in   1       asynchronous active-low reset
//  if_req     in   1       fetch request (read only)
//  if_addr    in   ADDR_W  fetch word address
//  if_gnt     out  1       fetch granted this cycle (combinational)
//  if_rvalid  out  1       if_rdata valid this cycle (1-cycle pulse)
//  if_rdata   out  DATA_W  fetch read data
//  d_req      in   1       data request
//  d_we       in   1       1 = write, 0 = read
//  d_addr     in   ADDR_W  data word address
//  d_wdata    in   DATA_W  write data
//  d_gnt      out  1       data granted this cycle (combinational)
//  d_rvalid   out  1       d_rdata valid this cycle (reads only, 1-cycle pulse)
//  d_rdata    out  DATA_W  data read data
//  mem_addr   out  ADDR_W  RAM address
//  mem_we     out  1       RAM write enable
//  mem_wdata  out  DATA_W  RAM write data
//  mem_rdata  in   DATA_W  RAM read data, valid the cycle after address is presented
// BEHAVIOUR
//  - Reset (RESET_N=0, async): owner_q=NONE, starve_q=0, if_rvalid=d_rvalid=0,
//    if_rdata=d_rdata=0. While RESET_N=0: if_gnt=d_gnt=0 and mem_we=0 regardless of reqs.
//    Reset mid-read discards the pending return; no rvalid follows release.
//  - Arbitration in cycle T (combinational):
//    - Only one req set: that port is granted.
//    - Both set: D granted, unless starve_q==STARVE_MAX, in which case IF is granted.
//    - No req: no grant, mem_we=0, mem_addr holds the last granted address.
//  - Exactly one gnt is high at a time. Requester holds req/addr/wdata until it sees gnt
//    and may drop them in T+1.
//  - Datapath in T: mem_addr/mem_we/mem_wdata come from the granted port.
//    mem_we = d_gnt & d_we.
//  - Read latency is 1: a read granted in T returns mem_rdata in T+1.
//    - owner_q (NONE/IF/D) is registered at the end of T.
//    - In T+1 the matching rvalid pulses and its rdata register captures mem_rdata.
//    - rdata registers hold their value until that owner's next rvalid.
//  - Writes: complete at the end of T, produce no rvalid, and set owner_q=NONE.
//  - Back-to-back accesses: a new grant in T+1 is legal while T's return is delivered.
//    Throughput is 1 access/cycle.
//  - Starvation counter starve_q (4 bits):
//    - Increments when if_req=1 and if_gnt=0.
//    - Clears when if_gnt=1 or if_req=0.
//    - Saturates at STARVE_MAX.
//  - Same address on both ports: no hazard handling. D write in T is seen by an IF read
//    in T+1 or later.
//  - Out-of-range addresses are not checked; the address wraps modulo 2**ADDR_W.
// STRUCTURE
//  - Shared package proc_pkg: localparams OWN_NONE=2'd0, OWN_IF=2'd1, OWN_D=2'd2;
//    ADDR_W and DATA_W defaults shared with the core.
//  - Sub-module arb_starve_ctr: the saturating starvation counter plus the force-IF
//    compare. Arbitration mux, owner register and rdata registers stay in this module.
// TESTING
//  1. Reset: hold RESET_N=0 with if_req=d_req=1
//     -> gnts=0, mem_we=0, rvalids=0, rdatas=0.
//  2. IF only: if_req=1, if_addr=0x0010, RAM[0x10]=0xDEADBEEF
//     -> if_gnt=1 in T; if_rvalid=1 and if_rdata=0xDEADBEEF in T+1; d_rvalid=0.
//  3. Write then read: D write 0x0020<-0x12345678 in T, D read 0x0020 in T+1
//     -> mem_we=1 only in T; d_rvalid=1 and d_rdata=0x12345678 in T+2.
//  4. Contention: both reqs held high continuously, STARVE_MAX=3
//     -> grant pattern D,D,D,IF repeating; each IF return lands in the cycle after its grant.
//  5. Pipelined mix: IF read 0x1, D read 0x2, IF read 0x3 granted in consecutive cycles
//     -> rvalids alternate IF,D,IF one cycle later; each rdata matches its address.
//  6. Reset mid-read: IF read granted in T, RESET_N=0 inside T+1
//     -> if_rvalid=0 and if_rdata=0; no late pulse after RESET_N returns to 1.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - widths and read-owner codes shared between the core and the memory arbiter
package proc_pkg;

  localparam int PROC_ADDR_W = 16;
  localparam int PROC_DATA_W = 32;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of consecutive denied fetch cycles and the force-fetch flag
module arb_starve_ctr #(
  parameter int STARVE_MAX = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_if_req,
  input  logic i_if_gnt,
  output logic o_force_if
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] r_starve;
  logic [3:0] w_starve_nxt;

  always_comb begin
    w_starve_nxt = r_starve;
    if (!i_if_req || i_if_gnt) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve != STARVE_LIM) begin
      w_starve_nxt = r_starve + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= 4'd0;
    end else begin
      r_starve <= w_starve_nxt;
    end
  end

  assign o_force_if = (r_starve == STARVE_LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port sync RAM between fetch and load/store ports
// Data wins by default; a fetch denied STARVE_MAX cycles in a row is forced through.
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W     = PROC_ADDR_W,
  parameter int DATA_W     = PROC_DATA_W,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              w_force_if;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic [1:0]        r_owner;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .i_clk     (CLOCK_50),
    .i_rst_n   (RESET_N),
    .i_if_req  (if_req),
    .i_if_gnt  (w_if_gnt),
    .o_force_if(w_force_if)
  );

  // Grants are gated by reset directly so nothing reaches the RAM while it is asserted.
  assign w_if_gnt = RESET_N & if_req & (~d_req | w_force_if);
  assign w_d_gnt  = RESET_N & d_req & ~w_if_gnt;

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign mem_we    = w_d_gnt & d_we;
  assign mem_wdata = d_wdata;

  always_comb begin
    mem_addr = r_last_addr;
    if (w_if_gnt) begin
      mem_addr = if_addr;
    end else if (w_d_gnt) begin
      mem_addr = d_addr;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_last_addr <= '0;
      r_owner     <= OWN_NONE;
    end else begin
      if (w_if_gnt || w_d_gnt) begin
        r_last_addr <= mem_addr;
      end
      if (w_if_gnt) begin
        r_owner <= OWN_IF;
      end else if (w_d_gnt && !d_we) begin
        r_owner <= OWN_D;
      end else begin
        r_owner <= OWN_NONE;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (r_owner == OWN_IF) begin
        r_if_rdata <= mem_rdata;
      end
      if (r_owner == OWN_D) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  // The return cycle forwards RAM data straight through; the registers only hold it afterwards.
  assign if_rvalid = (r_owner == OWN_IF);
  assign d_rvalid  = (r_owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : r_if_rdata;
  assign d_rdata   = d_rvalid ? mem_rdata : r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a behavioural RAM and reference model
module tb_mem_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int SMAX   = 3;

  logic              CLOCK_50 = 1'b0;
  logic              RESET_N;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] shadow [0:15];

  int checks = 0;
  int failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge CLOCK_50) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  task automatic next_cycle();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    RESET_N = 0;
    if_req = 1; if_addr = 16'h0005; d_req = 1; d_we = 1; d_addr = 16'h0006; d_wdata = 32'h1111_2222;
    next_cycle();
    next_cycle();
    #3;
    checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL reset_if_gnt got=%b exp=0", if_gnt); end
    checks++; if (d_gnt !== 1'b0) begin failures++; $display("FAIL reset_d_gnt got=%b exp=0", d_gnt); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if ({if_rvalid, d_rvalid} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", if_rvalid, d_rvalid); end
    checks++; if (if_rdata !== 32'h0) begin failures++; $display("FAIL reset_if_rdata got=%h exp=0", if_rdata); end
    checks++; if (d_rdata !== 32'h0) begin failures++; $display("FAIL reset_d_rdata got=%h exp=0", d_rdata); end
    next_cycle();
    idle_inputs();
    RESET_N = 1;
  endtask

  task automatic test_if_only();
    ram[16'h0010] = 32'hDEAD_BEEF;
    next_cycle();
    if_req = 1; if_addr = 16'h0010;
    #3;
    checks++; if ({if_gnt, d_gnt} !== 2'b10) begin failures++; $display("FAIL ifonly_gnt got=%b%b exp=10", if_gnt, d_gnt); end
    checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL ifonly_addr got=%h exp=0010", mem_addr); end
    next_cycle();
    if_req = 0;
    #3;
    checks++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin failures++; $display("FAIL ifonly_rvalid got=%b%b exp=10", if_rvalid, d_rvalid); end
    checks++; if (if_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ifonly_rdata got=%h exp=deadbeef", if_rdata); end
    checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL idle_addr_hold got=%h exp=0010", mem_addr); end
    next_cycle();
    #3;
    checks++; if (if_rvalid !== 1'b0) begin failures++; $display("FAIL ifonly_pulse got=%b exp=0", if_rvalid); end
    checks++; if (if_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ifonly_hold got=%h exp=deadbeef", if_rdata); end
  endtask

  task automatic test_write_read();
    next_cycle();
    d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 32'h1234_5678;
    #3;
    checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL wr_gnt_we got=%b%b exp=11", d_gnt, mem_we); end
    next_cycle();
    d_we = 0; d_wdata = '0;
    #3;
    checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL rd_gnt_we got=%b%b exp=10", d_gnt, mem_we); end
    checks++; if (d_rvalid !== 1'b0) begin failures++; $display("FAIL write_no_rvalid got=%b exp=0", d_rvalid); end
    next_cycle();
    d_req = 0;
    #3;
    checks++; if (d_rvalid !== 1'b1) begin failures++; $display("FAIL wrrd_rvalid got=%b exp=1", d_rvalid); end
    checks++; if (d_rdata !== 32'h1234_5678) begin failures++; $display("FAIL wrrd_rdata got=%h exp=12345678", d_rdata); end
    checks++; if (if_rvalid !== 1'b0) begin failures++; $display("FAIL wrrd_if_rvalid got=%b exp=0", if_rvalid); end
  endtask

  task automatic test_contention();
    logic prev_if, prev_d, e_if;
    ram[16'h0030] = 32'hA5A5_0030;
    ram[16'h0031] = 32'h5A5A_0031;
    prev_if = 0; prev_d = 0;
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      if_req = 1; if_addr = 16'h0030; d_req = 1; d_we = 0; d_addr = 16'h0031;
      #3;
      e_if = ((k % 4) == 3);
      checks++; if ({if_gnt, d_gnt} !== {e_if, ~e_if}) begin failures++; $display("FAIL contend_gnt k=%0d got=%b%b exp=%b%b", k, if_gnt, d_gnt, e_if, ~e_if); end
      checks++; if ({if_rvalid, d_rvalid} !== {prev_if, prev_d}) begin failures++; $display("FAIL contend_rvalid k=%0d got=%b%b exp=%b%b", k, if_rvalid, d_rvalid, prev_if, prev_d); end
      if (prev_if) begin
        checks++; if (if_rdata !== 32'hA5A5_0030) begin failures++; $display("FAIL contend_if_rdata k=%0d got=%h exp=a5a50030", k, if_rdata); end
      end
      prev_if = e_if; prev_d = ~e_if;
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_pipelined();
    ram[16'h0001] = 32'h0000_AAA1;
    ram[16'h0002] = 32'h0000_BBB2;
    ram[16'h0003] = 32'h0000_CCC3;
    next_cycle();
    if_req = 1; if_addr = 16'h0001;
    #3;
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL pipe_g0 got=%b exp=1", if_gnt); end
    next_cycle();
    if_req = 0; d_req = 1; d_we = 0; d_addr = 16'h0002;
    #3;
    checks++; if (d_gnt !== 1'b1 || if_rvalid !== 1'b1 || if_rdata !== 32'h0000_AAA1) begin failures++; $display("FAIL pipe_c1 got gnt=%b rv=%b rd=%h exp gnt=1 rv=1 rd=0000aaa1", d_gnt, if_rvalid, if_rdata); end
    next_cycle();
    d_req = 0; if_req = 1; if_addr = 16'h0003;
    #3;
    checks++; if (if_gnt !== 1'b1 || d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || d_rdata !== 32'h0000_BBB2) begin failures++; $display("FAIL pipe_c2 got gnt=%b drv=%b irv=%b rd=%h exp 1 1 0 0000bbb2", if_gnt, d_rvalid, if_rvalid, d_rdata); end
    next_cycle();
    if_req = 0;
    #3;
    checks++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== 32'h0000_CCC3) begin failures++; $display("FAIL pipe_c3 got irv=%b drv=%b rd=%h exp 1 0 0000ccc3", if_rvalid, d_rvalid, if_rdata); end
  endtask

  task automatic test_reset_mid_read();
    ram[16'h0040] = 32'hCAFE_F00D;
    next_cycle();
    if_req = 1; if_addr = 16'h0040;
    next_cycle();
    if_req = 0;
    #1;
    RESET_N = 0;
    #2;
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin failures++; $display("FAIL midrst got rv=%b rd=%h exp rv=0 rd=0", if_rvalid, if_rdata); end
    next_cycle();
    RESET_N = 1;
    for (int k = 0; k < 3; k++) begin
      #3;
      checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin failures++; $display("FAIL midrst_late k=%0d got rv=%b rd=%h exp 0 0", k, if_rvalid, if_rdata); end
      next_cycle();
    end
  endtask

  task automatic test_random();
    int m_starve;
    logic e_ig, e_dg, p_valid, p_is_if, hold_if, hold_d;
    logic [DATA_W-1:0] p_data, e_ifd, e_dd, exp_ifd, exp_dd;
    next_cycle();
    RESET_N = 0;
    idle_inputs();
    for (int a = 0; a < 16; a++) begin
      shadow[a] = $urandom;
      ram[a] = shadow[a];
    end
    next_cycle();
    RESET_N = 1;
    m_starve = 0; p_valid = 0; p_is_if = 0; p_data = '0; e_ifd = '0; e_dd = '0;
    hold_if = 0; hold_d = 0;
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      if (!hold_if) begin
        if_req = ($urandom_range(0, 9) < 7);
        if_addr = 16'($urandom_range(0, 15));
      end
      if (!hold_d) begin
        d_req = ($urandom_range(0, 9) < 7);
        d_we = $urandom_range(0, 1) == 1;
        d_addr = 16'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      e_ig = if_req && (!d_req || m_starve == SMAX);
      e_dg = d_req && !e_ig;
      exp_ifd = (p_valid && p_is_if) ? p_data : e_ifd;
      exp_dd = (p_valid && !p_is_if) ? p_data : e_dd;
      #3;
      checks++; if ({if_gnt, d_gnt} !== {e_ig, e_dg}) begin failures++; $display("FAIL rnd_gnt c=%0d got=%b%b exp=%b%b", c, if_gnt, d_gnt, e_ig, e_dg); end
      checks++; if (mem_we !== (e_dg && d_we)) begin failures++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, mem_we, e_dg && d_we); end
      if (e_ig || e_dg) begin
        checks++; if (mem_addr !== (e_ig ? if_addr : d_addr)) begin failures++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, mem_addr, e_ig ? if_addr : d_addr); end
      end
      checks++; if ({if_rvalid, d_rvalid} !== {p_valid && p_is_if, p_valid && !p_is_if}) begin failures++; $display("FAIL rnd_rvalid c=%0d got=%b%b exp=%b%b", c, if_rvalid, d_rvalid, p_valid && p_is_if, p_valid && !p_is_if); end
      checks++; if (if_rdata !== exp_ifd) begin failures++; $display("FAIL rnd_if_rdata c=%0d got=%h exp=%h", c, if_rdata, exp_ifd); end
      checks++; if (d_rdata !== exp_dd) begin failures++; $display("FAIL rnd_d_rdata c=%0d got=%h exp=%h", c, d_rdata, exp_dd); end
      e_ifd = exp_ifd;
      e_dd = exp_dd;
      p_valid = e_ig || (e_dg && !d_we);
      p_is_if = e_ig;
      p_data = e_ig ? shadow[if_addr[3:0]] : shadow[d_addr[3:0]];
      if (e_dg && d_we) shadow[d_addr[3:0]] = d_wdata;
      m_starve = (if_req && !e_ig) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
      hold_if = if_req && !e_ig;
      hold_d = d_req && !e_dg;
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    RESET_N = 0;
    test_reset();
    test_if_only();
    test_write_read();
    test_contention();
    test_pipelined();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
